// File: rtl/vram_data_port_if.sv
// Memory-bus link between a VRAM master and the memory-bus arbiter.
// The master holds the request (strobe plus address/data/lane) until the
// slave answers with a one-cycle ack; read data is valid in the ack cycle.
interface vram_data_port_if #(
    parameter int ADDR_WIDTH = 18
);
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [31:0]           bus_wrdata;
    logic [3:0]            bus_bytesel;
    logic                  bus_write;
    logic                  bus_strobe;
    logic                  bus_ack;
    logic [31:0]           bus_rddata;

    modport master (
        output bus_addr, bus_wrdata, bus_bytesel, bus_write, bus_strobe,
        input  bus_ack, bus_rddata
    );

    modport slave (
        input  bus_addr, bus_wrdata, bus_bytesel, bus_write, bus_strobe,
        output bus_ack, bus_rddata
    );
endinterface

// File: rtl/vram_data_port.sv
// Host-facing VRAM data port: a 4-byte register window (ADDR_L, ADDR_M,
// ADDR_H, DATA) turned into byte-wide memory-bus transactions, with address
// auto-increment and a read-prefetch latch so DATA reads never wait.
// Optional feature: define VRAM_PORT_DECR_EN to make ADDR_H bit 3 a
// read/write "decrement" bit; otherwise bit 3 reads 0 and the step is added.
// ADDR_H maps bits [1:0] onto addr[17:16], so ADDR_WIDTH is expected to be 18.
module vram_data_port #(
    parameter int ADDR_WIDTH = 18,
    parameter int INCR_BITS  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             regs_addr_i,
    input  logic [7:0]             regs_wrdata_i,
    input  logic                   regs_write_i,
    input  logic                   regs_read_i,
    output logic [7:0]             regs_rddata_o,
    output logic                   busy_o,
    vram_data_port_if.master       bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FETCH = 2'd2
    } state_t;

    localparam logic [1:0] REG_ADDR_L = 2'd0;
    localparam logic [1:0] REG_ADDR_M = 2'd1;
    localparam logic [1:0] REG_ADDR_H = 2'd2;
    localparam logic [1:0] REG_DATA   = 2'd3;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [INCR_BITS-1:0]    incr_q, incr_d;
    logic                    decr_q, decr_d;
    logic                    err_q, err_d;
    logic [7:0]              latch_q, latch_d;
    logic                    slot_full_q, slot_full_d;
    logic [ADDR_WIDTH-1:0]   slot_addr_q, slot_addr_d;
    logic [7:0]              slot_data_q, slot_data_d;
    logic                    fetch_needed_q, fetch_needed_d;
    logic [ADDR_WIDTH-1:0]   op_addr_q, op_addr_d;
    logic [7:0]              op_data_q, op_data_d;

    logic [ADDR_WIDTH-1:0]   step;
    logic [ADDR_WIDTH-1:0]   addr_adv;
    logic                    start_write;
    logic                    start_fetch;
    logic                    slot_blocked;

    // IDLE launches the pending write first, otherwise a needed prefetch.
    assign start_write  = (state_q == ST_IDLE) && slot_full_q;
    assign start_fetch  = (state_q == ST_IDLE) && !slot_full_q && fetch_needed_q;
    // A slot being handed to the bus this cycle can accept a new write.
    assign slot_blocked = slot_full_q && !start_write;

    // Step decode: incr=0 holds the address, incr=n steps by 1<<(n-1).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        step = '0;
        if (incr_q != '0) begin
            step = ADDR_WIDTH'(1) << (incr_q - INCR_BITS'(1));
        end
    end

    // Advanced address; wraps modulo 2^ADDR_WIDTH through natural truncation.
    assign addr_adv = decr_q ? (addr_q - step) : (addr_q + step);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    // FSM next-state: one transaction at a time, back to IDLE on every ack.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_write) begin
                    state_d = ST_WRITE;
                end else if (start_fetch) begin
                    state_d = ST_FETCH;
                end
            end
            ST_WRITE, ST_FETCH: begin
                if (bus.bus_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: bus request driven only from registered state and operands.
    always_comb begin
        bus.bus_strobe  = 1'b0;
        bus.bus_write   = 1'b0;
        bus.bus_addr    = '0;
        bus.bus_wrdata  = '0;
        bus.bus_bytesel = '0;
        unique case (state_q)
            ST_WRITE: begin
                bus.bus_strobe  = 1'b1;
                bus.bus_write   = 1'b1;
                bus.bus_addr    = op_addr_q;
                bus.bus_wrdata  = {4{op_data_q}};
                bus.bus_bytesel = 4'b0001 << op_addr_q[1:0];
            end
            ST_FETCH: begin
                bus.bus_strobe  = 1'b1;
                bus.bus_addr    = op_addr_q;
                bus.bus_bytesel = 4'b0001 << op_addr_q[1:0];
            end
            default: ;
        endcase
    end

    // Datapath next-state: host register side effects, slot, prefetch latch.
    always_comb begin
        addr_d         = addr_q;
        incr_d         = incr_q;
        decr_d         = decr_q;
        err_d          = err_q;
        latch_d        = latch_q;
        slot_full_d    = slot_full_q;
        slot_addr_d    = slot_addr_q;
        slot_data_d    = slot_data_q;
        fetch_needed_d = fetch_needed_q;
        op_addr_d      = op_addr_q;
        op_data_d      = op_data_q;

        // Move the pending write onto the bus, or snapshot addr for a prefetch.
        if (start_write) begin
            op_addr_d   = slot_addr_q;
            op_data_d   = slot_data_q;
            slot_full_d = 1'b0;
        end else if (start_fetch) begin
            op_addr_d      = addr_q;
            fetch_needed_d = 1'b0;
        end

        if ((state_q == ST_FETCH) && bus.bus_ack) begin
            latch_d = bus.bus_rddata[{op_addr_q[1:0], 3'b000} +: 8];
        end

        // Host accesses come last so a new prefetch request beats a clear.
        if (regs_write_i) begin
            unique case (regs_addr_i)
                REG_ADDR_L: begin
                    addr_d[7:0]    = regs_wrdata_i;
                    fetch_needed_d = 1'b1;
                end
                REG_ADDR_M: begin
                    addr_d[15:8]   = regs_wrdata_i;
                    fetch_needed_d = 1'b1;
                end
                REG_ADDR_H: begin
                    incr_d                  = regs_wrdata_i[4 +: INCR_BITS];
`ifdef VRAM_PORT_DECR_EN
                    decr_d                  = regs_wrdata_i[3];
`else
                    decr_d                  = 1'b0;
`endif
                    addr_d[ADDR_WIDTH-1:16] = regs_wrdata_i[ADDR_WIDTH-17:0];
                    err_d                   = 1'b0;
                    fetch_needed_d          = 1'b1;
                end
                default: begin
                    if (slot_blocked) begin
                        err_d = 1'b1;
                    end else begin
                        slot_full_d = 1'b1;
                        slot_addr_d = addr_q;
                        slot_data_d = regs_wrdata_i;
                    end
                    addr_d         = addr_adv;
                    fetch_needed_d = 1'b1;
                end
            endcase
        end else if (regs_read_i && (regs_addr_i == REG_DATA)) begin
            addr_d         = addr_adv;
            fetch_needed_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q         <= '0;
            incr_q         <= '0;
            decr_q         <= 1'b0;
            err_q          <= 1'b0;
            latch_q        <= '0;
            slot_full_q    <= 1'b0;
            slot_addr_q    <= '0;
            slot_data_q    <= '0;
            fetch_needed_q <= 1'b0;
            op_addr_q      <= '0;
            op_data_q      <= '0;
        end else begin
            addr_q         <= addr_d;
            incr_q         <= incr_d;
            decr_q         <= decr_d;
            err_q          <= err_d;
            latch_q        <= latch_d;
            slot_full_q    <= slot_full_d;
            slot_addr_q    <= slot_addr_d;
            slot_data_q    <= slot_data_d;
            fetch_needed_q <= fetch_needed_d;
            op_addr_q      <= op_addr_d;
            op_data_q      <= op_data_d;
        end
    end

    // Host read mux, combinational on regs_addr_i.
    always_comb begin
        regs_rddata_o = '0;
        unique case (regs_addr_i)
            REG_ADDR_L: regs_rddata_o = addr_q[7:0];
            REG_ADDR_M: regs_rddata_o = addr_q[15:8];
            REG_ADDR_H: regs_rddata_o = {incr_q, decr_q, err_q, addr_q[ADDR_WIDTH-1:16]};
            default:    regs_rddata_o = latch_q;
        endcase
    end

    assign busy_o = (state_q != ST_IDLE) || slot_full_q || fetch_needed_q;

endmodule

// File: tb/tb_vram_data_port.sv
// Directed bench for vram_data_port: table-driven register vectors plus
// hand-written sequences for write, prefetch, wrap, overflow, reset and decr.
module tb_vram_data_port;

    localparam int AW        = 18;
    localparam int ACK_DELAY = 1;

    typedef struct {
        bit        wr;
        bit [1:0]  ra;
        bit [7:0]  data;
        bit [7:0]  exp;
        string     name;
    } vec_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    bsel;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  regs_addr;
    logic [7:0]  regs_wrdata;
    logic        regs_write;
    logic        regs_read;
    logic [7:0]  regs_rddata;
    logic        busy;

    vram_data_port_if #(.ADDR_WIDTH(AW)) bus_if ();

    vram_data_port #(.ADDR_WIDTH(AW), .INCR_BITS(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .regs_addr_i   (regs_addr),
        .regs_wrdata_i (regs_wrdata),
        .regs_write_i  (regs_write),
        .regs_read_i   (regs_read),
        .regs_rddata_o (regs_rddata),
        .busy_o        (busy),
        .bus           (bus_if)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          hold_ack = 1'b0;
    int          ack_wait = 0;
    logic [31:0] mem [int];
    txn_t        log_q [$];
    vec_t        vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory-bus slave: acks ACK_DELAY cycles into each strobe, logs every op.
    initial begin
        bus_if.bus_ack    = 1'b0;
        bus_if.bus_rddata = '0;
        forever begin
            @(negedge clk);
            if (bus_if.bus_ack) begin
                bus_if.bus_ack = 1'b0;
                ack_wait       = 0;
            end else if (bus_if.bus_strobe && !hold_ack) begin
                if (ack_wait >= ACK_DELAY) begin
                    txn_t        t;
                    int          idx;
                    logic [31:0] word;
                    t.wr   = bus_if.bus_write;
                    t.addr = bus_if.bus_addr;
                    t.data = bus_if.bus_wrdata;
                    t.bsel = bus_if.bus_bytesel;
                    check("bytesel_lane", {28'd0, t.bsel}, {28'd0, 4'b0001 << t.addr[1:0]});
                    idx  = int'(t.addr >> 2);
                    word = mem.exists(idx) ? mem[idx] : 32'h0;
                    if (t.wr) begin
                        for (int l = 0; l < 4; l++) begin
                            if (t.bsel[l]) word[8*l +: 8] = t.data[8*l +: 8];
                        end
                        mem[idx] = word;
                    end else begin
                        bus_if.bus_rddata = word;
                    end
                    log_q.push_back(t);
                    bus_if.bus_ack = 1'b1;
                end else begin
                    ack_wait++;
                end
            end else if (!bus_if.bus_strobe) begin
                ack_wait = 0;
            end
        end
    end

    task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
        regs_addr   = a;
        regs_wrdata = d;
        regs_write  = 1'b1;
        @(posedge clk);
        #1;
        regs_write  = 1'b0;
    endtask

    task automatic data_read_strobe();
        regs_addr = 2'd3;
        regs_read = 1'b1;
        @(posedge clk);
        #1;
        regs_read = 1'b0;
    endtask

    task automatic check_reg(input logic [1:0] a, input logic [7:0] exp, input string name);
        regs_addr = a;
        #1;
        check(name, {24'd0, regs_rddata}, {24'd0, exp});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 300);
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic set_addr(input logic [7:0] l, input logic [7:0] m, input logic [7:0] h);
        reg_write(2'd0, l);
        reg_write(2'd1, m);
        reg_write(2'd2, h);
        wait_idle("set_addr_idle");
    endtask

    task automatic add_vec(input bit wr, input bit [1:0] ra, input bit [7:0] data,
                           input bit [7:0] exp, input string name);
        vec_t v;
        v.wr = wr; v.ra = ra; v.data = data; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [7:0] h_exp;
        rst_n       = 1'b0;
        regs_addr   = 2'd0;
        regs_wrdata = 8'h00;
        regs_write  = 1'b0;
        regs_read   = 1'b0;
        mem[int'(18'h01234 >> 2)] = 32'h44332211;

        // Reset state.
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_strobe", {31'd0, bus_if.bus_strobe}, 32'd0);
        check("rst_bus_addr", {14'd0, bus_if.bus_addr}, 32'd0);
        check("rst_bytesel", {28'd0, bus_if.bus_bytesel}, 32'd0);
        check("rst_write", {31'd0, bus_if.bus_write}, 32'd0);
        check_reg(2'd0, 8'h00, "rst_addr_l");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Register vectors: writes wait for the follow-up prefetch.
`ifdef VRAM_PORT_DECR_EN
        h_exp = 8'h19;
`else
        h_exp = 8'h11;
`endif
        add_vec(1, 2'd0, 8'h34, 8'h00, "wr_l");
        add_vec(1, 2'd1, 8'h12, 8'h00, "wr_m");
        add_vec(1, 2'd2, 8'h10, 8'h00, "wr_h");
        add_vec(0, 2'd0, 8'h00, 8'h34, "rd_l");
        add_vec(0, 2'd1, 8'h00, 8'h12, "rd_m");
        add_vec(0, 2'd2, 8'h00, 8'h10, "rd_h");
        add_vec(0, 2'd3, 8'h00, 8'h11, "rd_data_prefetch");
        add_vec(1, 2'd2, 8'h1D, 8'h00, "wr_h_ro_bits");
        add_vec(0, 2'd2, 8'h00, h_exp, "rd_h_ro_bits");
        add_vec(0, 2'd1, 8'h00, 8'h12, "rd_m_unchanged");
        add_vec(1, 2'd2, 8'h10, 8'h00, "wr_h_restore");
        add_vec(0, 2'd2, 8'h00, 8'h10, "rd_h_restore");
        add_vec(1, 2'd0, 8'hFF, 8'h00, "wr_l_ff");
        add_vec(0, 2'd0, 8'h00, 8'hFF, "rd_l_ff");
        add_vec(0, 2'd3, 8'h00, 8'h00, "rd_data_empty");
        add_vec(1, 2'd0, 8'h34, 8'h00, "wr_l_back");
        add_vec(0, 2'd3, 8'h00, 8'h11, "rd_data_again");
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                reg_write(vecs[i].ra, vecs[i].data);
                wait_idle({vecs[i].name, "_idle"});
            end else begin
                check_reg(vecs[i].ra, vecs[i].exp, vecs[i].name);
            end
        end

        // Basic write: write at 0x01234, then prefetch at 0x01235.
        log_q.delete();
        reg_write(2'd3, 8'hAB);
        wait_idle("bw_idle");
        check("bw_ntxn", 32'(log_q.size()), 32'd2);
        if (log_q.size() >= 2) begin
            check("bw_w_is_write", {31'd0, log_q[0].wr}, 32'd1);
            check("bw_w_addr", {14'd0, log_q[0].addr}, 32'h01234);
            check("bw_w_bsel", {28'd0, log_q[0].bsel}, 32'h1);
            check("bw_w_data", log_q[0].data, 32'hABABABAB);
            check("bw_r_is_read", {31'd0, log_q[1].wr}, 32'd0);
            check("bw_r_addr", {14'd0, log_q[1].addr}, 32'h01235);
        end
        check_reg(2'd0, 8'h35, "bw_addr_l");
        check_reg(2'd3, 8'h22, "bw_data_lane1");

        // Prefetch: lane 2 at 0x01236, then a DATA read fetches 0x01237.
        set_addr(8'h36, 8'h12, 8'h10);
        check_reg(2'd3, 8'h33, "pf_data_lane2");
        log_q.delete();
        data_read_strobe();
        wait_idle("pf_idle");
        check("pf_ntxn", 32'(log_q.size()), 32'd1);
        if (log_q.size() >= 1) check("pf_addr", {14'd0, log_q[0].addr}, 32'h01237);
        check_reg(2'd3, 8'h44, "pf_data_lane3");
        check_reg(2'd0, 8'h37, "pf_addr_l");

        // Wrap with incr=1 from 0x3FFFF.
        set_addr(8'hFF, 8'hFF, 8'h13);
        log_q.delete();
        data_read_strobe();
        wait_idle("wrap1_idle");
        check_reg(2'd0, 8'h00, "wrap1_l");
        check_reg(2'd1, 8'h00, "wrap1_m");
        check_reg(2'd2, 8'h10, "wrap1_h");
        check("wrap1_ntxn", 32'(log_q.size()), 32'd1);
        if (log_q.size() >= 1) check("wrap1_fetch_addr", {14'd0, log_q[0].addr}, 32'h0);

        // Wrap with incr=15 (step 0x4000) from 0x3C000.
        set_addr(8'h00, 8'hC0, 8'hF3);
        data_read_strobe();
        wait_idle("wrap2_idle");
        check_reg(2'd1, 8'h00, "wrap2_m");
        check_reg(2'd2, 8'hF0, "wrap2_h");

        // incr=0: DATA read leaves the address where it is.
        set_addr(8'h55, 8'h00, 8'h00);
        data_read_strobe();
        wait_idle("step0_idle");
        check_reg(2'd0, 8'h55, "step0_l");

        // Overflow: stalled bus, three back-to-back DATA writes.
        set_addr(8'h00, 8'h20, 8'h10);
        log_q.delete();
        hold_ack = 1'b1;
        reg_write(2'd3, 8'hA1);
        reg_write(2'd3, 8'hA2);
        reg_write(2'd3, 8'hA3);
        check("ovf_strobe", {31'd0, bus_if.bus_strobe}, 32'd1);
        check("ovf_bus_addr", {14'd0, bus_if.bus_addr}, 32'h02000);
        check("ovf_bus_data", bus_if.bus_wrdata, 32'hA1A1A1A1);
        check_reg(2'd2, 8'h14, "ovf_err_set");
        check("ovf_busy", {31'd0, busy}, 32'd1);
        hold_ack = 1'b0;
        wait_idle("ovf_idle");
        check("ovf_ntxn", 32'(log_q.size()), 32'd3);
        if (log_q.size() >= 3) begin
            check("ovf_2nd_write", {31'd0, log_q[1].wr}, 32'd1);
            check("ovf_2nd_addr", {14'd0, log_q[1].addr}, 32'h02001);
            check("ovf_2nd_data", log_q[1].data, 32'hA2A2A2A2);
            check("ovf_3rd_is_read", {31'd0, log_q[2].wr}, 32'd0);
        end
        check_reg(2'd2, 8'h14, "ovf_err_sticky");
        reg_write(2'd2, 8'h10);
        wait_idle("ovf_clr_idle");
        check_reg(2'd2, 8'h10, "ovf_err_cleared");

        // Reset in the middle of a stalled WRITE.
        hold_ack = 1'b1;
        reg_write(2'd3, 8'h5A);
        for (int n = 0; n < 20 && !bus_if.bus_strobe; n++) @(negedge clk);
        check("rmo_strobe_before", {31'd0, bus_if.bus_strobe}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rmo_strobe_now", {31'd0, bus_if.bus_strobe}, 32'd0);
        check("rmo_busy_now", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        hold_ack = 1'b0;
        check_reg(2'd0, 8'h00, "rmo_l");
        check_reg(2'd1, 8'h00, "rmo_m");
        check_reg(2'd2, 8'h00, "rmo_h");
        check_reg(2'd3, 8'h00, "rmo_data");
        @(posedge clk);
        #1;

        // Decrement bit (step 4 from 0x00004), or its absence.
`ifdef VRAM_PORT_DECR_EN
        set_addr(8'h04, 8'h00, 8'h38);
        check_reg(2'd2, 8'h38, "decr_h");
`else
        set_addr(8'h04, 8'h00, 8'h38);
        check_reg(2'd2, 8'h30, "nodecr_h");
`endif
        log_q.delete();
        reg_write(2'd3, 8'h77);
        wait_idle("decr_idle");
        if (log_q.size() >= 1) check("decr_write_addr", {14'd0, log_q[0].addr}, 32'h00004);
        check("decr_ntxn", 32'(log_q.size()), 32'd2);
`ifdef VRAM_PORT_DECR_EN
        check_reg(2'd0, 8'h00, "decr_next_l");
`else
        check_reg(2'd0, 8'h08, "nodecr_next_l");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
